// File: rtl/tt_bist_pkg.sv
// Shared types and helpers for the Tiny Tapeout BIST harness.
package tt_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    MODE_LFSR = 2'b00,
    MODE_WALK = 2'b01,
    MODE_CNT  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  // Widest datapath supported; narrower callers zero-extend and truncate.
  localparam int unsigned MAX_WIDTH = 16;

  // One right-shifting Galois LFSR step, used by both the pattern LFSR and the MISR.
  function automatic logic [MAX_WIDTH-1:0] galois_step(input logic [MAX_WIDTH-1:0] value,
                                                       input logic [MAX_WIDTH-1:0] poly);
    galois_step = value[0] ? ((value >> 1) ^ poly) : (value >> 1);
  endfunction

endpackage

// File: rtl/tt_bist_harness_misr.sv
// Multiple-input signature register compressing core responses.
module tt_bist_misr
  import tt_bist_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'hB8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clr,
  input  logic             cap,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  // Signature register: clear at run start, fold in one response per capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (ena) begin
      if (clr) begin
        sig <= '0;
      end else if (cap) begin
        sig <= WIDTH'(galois_step(MAX_WIDTH'(sig), MAX_WIDTH'(POLY))) ^ data;
      end
    end
  end

endmodule

// File: rtl/tt_bist_harness.sv
// BIST harness between the TT pins and a user core: bypass, pattern run, MISR check.
module tt_bist_harness
  import tt_bist_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      N_CYCLES = 256,
  parameter int unsigned      CORE_LAT = 1,
  parameter logic [WIDTH-1:0] POLY     = 8'hB8,
  parameter logic [WIDTH-1:0] SEED     = 8'h01,
  parameter logic [WIDTH-1:0] GOLDEN   = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] byp_in,
  output logic [WIDTH-1:0] core_in,
  input  logic [WIDTH-1:0] core_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  // One counter serves both the RUN length and the DRAIN length.
  localparam int unsigned     CNT_MAX    = (N_CYCLES > CORE_LAT) ? N_CYCLES : CORE_LAT;
  localparam int unsigned     CW         = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]   RUN_LAST   = CW'(N_CYCLES - 1);
  localparam logic [CW-1:0]   DRAIN_LAST = CW'((CORE_LAT > 0) ? CORE_LAT - 1 : 0);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sig_clr;
  logic             in_run;
  logic             cap_vld;

  function automatic logic [WIDTH-1:0] next_pattern(input mode_t m, input logic [WIDTH-1:0] p);
    case (m)
      MODE_WALK: next_pattern = {p[WIDTH-2:0], p[WIDTH-1]};
      MODE_CNT:  next_pattern = p + WIDTH'(1);
      default:   next_pattern = WIDTH'(galois_step(MAX_WIDTH'(p), MAX_WIDTH'(POLY)));
    endcase
  endfunction

  // State, latched mode, pattern and cycle counter; frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= MODE_LFSR;
      pattern_q <= SEED;
      count_q   <= '0;
    end else if (ena) begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      count_q   <= count_d;
    end
  end

  // Next-state logic; the last RUN cycle does not advance so DRAIN holds the last applied pattern.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pattern_d = pattern_q;
    count_d   = count_q;
    sig_clr   = 1'b0;
    in_run    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start && (mode_t'(mode) != MODE_RSVD)) begin
          mode_d    = mode_t'(mode);
          pattern_d = SEED;
          count_d   = '0;
          sig_clr   = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        in_run = 1'b1;
        if (count_q == RUN_LAST) begin
          count_d = '0;
          state_d = (CORE_LAT == 0) ? DONE : DRAIN;
        end else begin
          count_d   = count_q + CW'(1);
          pattern_d = next_pattern(mode_q, pattern_q);
        end
      end
      DRAIN: begin
        if (count_q == DRAIN_LAST) begin
          count_d = '0;
          state_d = DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture-valid delay line matching the core latency.
  if (CORE_LAT == 0) begin : g_nolat
    assign cap_vld = in_run;
  end else begin : g_lat
    logic [CORE_LAT-1:0] vpipe;

    // Shift one valid bit per RUN cycle towards the capture point.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vpipe <= '0;
      end else if (ena) begin
        vpipe <= (vpipe << 1) | CORE_LAT'(in_run);
      end
    end

    assign cap_vld = vpipe[CORE_LAT-1];
  end

  tt_bist_misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .clr   (sig_clr),
    .cap   (cap_vld),
    .data  (core_out),
    .sig   (signature)
  );

  assign busy    = (state_q == RUN) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign pass    = done && (signature == GOLDEN);
  assign core_in = busy ? pattern_q : byp_in;

endmodule

// File: tb/tb_tt_bist_harness.sv
// Randomised self-checking bench for tt_bist_harness with a behavioural core and reference model.
module tb_tt_bist_harness;

  localparam int N_A = 8;
  localparam int L_A = 2;
  localparam int N_B = 4;
  localparam int L_B = 0;

  logic       clk = 1'b0;
  logic       rst_n, ena, start;
  logic [1:0] mode;
  logic [7:0] byp_in;
  logic [7:0] core_in_a, core_out_a, sig_a;
  logic [7:0] core_in_b, core_out_b, sig_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;

  int n_tests = 0;
  int n_fail  = 0;
  int fsel    = 0;
  int key     = 0;
  int last_seq[16];

  logic [7:0] d1, d2;

  always #5 clk = ~clk;

  tt_bist_harness #(
    .WIDTH(8), .N_CYCLES(N_A), .CORE_LAT(L_A), .POLY(8'hB8), .SEED(8'h01), .GOLDEN(8'h00)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .mode(mode), .byp_in(byp_in),
    .core_in(core_in_a), .core_out(core_out_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .signature(sig_a)
  );

  tt_bist_harness #(
    .WIDTH(8), .N_CYCLES(N_B), .CORE_LAT(L_B), .POLY(8'hB8), .SEED(8'h01), .GOLDEN(8'h2B)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .mode(mode), .byp_in(byp_in),
    .core_in(core_in_b), .core_out(core_out_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .signature(sig_b)
  );

  // Behavioural user core response.
  function automatic int core_fn(input int fs, input int k, input int x);
    case (fs)
      0:       return 0;
      1:       return x;
      2:       return x ^ k;
      default: return ((x % 16) * 16 + x / 16 + k) % 256;
    endcase
  endfunction

  function automatic int model_step(input int v);
    return (v % 2 == 1) ? ((v / 2) ^ 'hB8) : (v / 2);
  endfunction

  function automatic int model_next(input int m, input int p);
    case (m)
      0:       return model_step(p);
      1:       return (p * 2) % 256 + p / 128;
      default: return (p + 1) % 256;
    endcase
  endfunction

  function automatic int model_sig(input int m, input int n, input int fs, input int k);
    int p = 1;
    int s = 0;
    for (int i = 0; i < n; i++) begin
      s = model_step(s) ^ core_fn(fs, k, p);
      p = model_next(m, p);
    end
    return s;
  endfunction

  // Core with two clocks of latency, sharing the design enable.
  always_ff @(posedge clk) begin
    if (ena) begin
      d1 <= core_in_a;
      d2 <= d1;
    end
  end
  assign core_out_a = 8'(core_fn(fsel, key, int'(d2)));
  assign core_out_b = 8'(core_fn(fsel, key, int'(core_in_b)));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_run(input int m, input int fs, input int k, input int frz_at,
                        input int frz_len, input bit poke, input bit chg_mode);
    int en_edges = 0;
    int wall = 0;
    int busy_cnt = 0;
    int nseq = 0;
    int lat_a = -1;
    int lat_b = -1;
    int wall_a = -1;
    int frz_left = 0;
    bit froze = 1'b0;
    bit en_prev = 1'b1;
    int exp_a, exp_b, p;

    fsel   = fs;
    key    = k;
    byp_in = 8'($urandom);
    mode   = 2'(m);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200 && !(lat_a >= 0 && lat_b >= 0); c++) begin
      if (en_prev && busy_a) begin
        busy_cnt++;
        if (nseq < N_A) begin
          last_seq[nseq] = int'(core_in_a);
          nseq++;
        end
      end
      if (done_a && lat_a < 0) begin
        lat_a  = en_edges;
        wall_a = wall;
      end
      if (done_b && lat_b < 0) lat_b = en_edges;
      if (!froze && en_edges == frz_at && frz_len > 0) begin
        frz_left = frz_len;
        froze    = 1'b1;
      end
      ena = (frz_left == 0);
      if (frz_left > 0) frz_left--;
      start = poke && (c == 1);
      if (chg_mode && c == 2) mode = 2'($urandom_range(0, 3));
      en_prev = ena;
      @(posedge clk); #1;
      if (en_prev) en_edges++;
      wall++;
    end
    ena   = 1'b1;
    start = 1'b0;
    exp_a = model_sig(m, N_A, fs, k);
    exp_b = model_sig(m, N_B, fs, k);
    check("lat_a", lat_a, N_A + L_A);
    check("lat_b", lat_b, N_B + L_B);
    check("wall_a", wall_a, N_A + L_A + (frz_at < N_A + L_A ? frz_len : 0));
    check("busy_a_len", busy_cnt, N_A + L_A);
    p = 1;
    for (int i = 0; i < N_A; i++) begin
      check($sformatf("seq_a[%0d]", i), last_seq[i], p);
      p = model_next(m, p);
    end
    check("sig_a", sig_a, exp_a);
    check("sig_b", sig_b, exp_b);
    check("pass_a", pass_a, exp_a == 0);
    check("pass_b", pass_b, exp_b == 'h2B);
    check("done_a", done_a, 1);
    check("byp_a", core_in_a, byp_in);
  endtask

  initial begin
    int lfsr_ref[6];
    lfsr_ref = '{'h01, 'hB8, 'h5C, 'h2E, 'h17, 'hB3};
    rst_n  = 1'b0;
    ena    = 1'b1;
    start  = 1'b0;
    mode   = 2'b00;
    byp_in = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_core_in", core_in_a, 8'h5A);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_sig", sig_a, 0);

    // Reserved mode must not start a run.
    mode  = 2'b11;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("rsvd_busy_a", busy_a, 0);
    check("rsvd_busy_b", busy_b, 0);
    check("rsvd_core_in", core_in_a, byp_in);

    // Counter loopback.
    do_run(2, 1, 0, 0, 0, 1'b0, 1'b0);
    check("cnt_sig_b", sig_b, 8'h2B);
    check("cnt_pass_b", pass_b, 1);

    // LFSR sequence.
    do_run(0, 2, 'h33, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) check($sformatf("lfsr_seq[%0d]", i), last_seq[i], lfsr_ref[i]);

    // Walking one with a silent core.
    do_run(1, 0, 0, 0, 0, 1'b0, 1'b0);
    check("walk_sig_a", sig_a, 0);
    check("walk_pass_a", pass_a, 1);

    // Freeze mid-run, restart poke and mode change during RUN.
    do_run(2, 3, 'h5C, 3, 3, 1'b1, 1'b1);

    // Reset in the middle of a run.
    mode  = 2'b01;
    fsel  = 3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_sig", sig_a, 0);
    check("mid_rst_core_in", core_in_a, byp_in);
    check("mid_rst_busy_b", busy_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_run(1, 3, 'hA7, 0, 0, 1'b0, 1'b0);

    // Randomised runs.
    for (int r = 0; r < 20; r++) begin
      do_run($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 255),
             $urandom_range(2, 5), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
